mem_arbiter: RTL

Shares the single unified 16-bit memory between the fetch stage (read-only) and the memory stage (read/write) of the processor. It accepts one request at a time from each side and grants data over fetch, with a bounded-run fairness rule. It drives a variable-latency memory port, then returns read data with a one-cycle done pulse. Misaligned accesses and memory timeouts are reported as per-requester errors; the proc error output ORs these in.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_watchdog.sv | 29 ++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, FSM state and owner encodings for mem_arbiter
package mem_arb_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - 8-bit memory response watchdog with clear and enable
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // High in the enabled cycle whose increment brings the count to TIMEOUT.
    assign expired = en && (({1'b0, cnt} + 9'd1) == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared 16-bit memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          mem_abort,
    output logic          busy
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    state_t        state, next_state;
    logic [3:0]    run;
    owner_t        owner_q, owner_n;
    logic [AW-1:0] addr_q, addr_n;
    logic          wr_q, wr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic          grant_d, grant_f, in_mem, wd_expired;

    logic          f_done_n, f_err_n, d_done_n, d_err_n;
    logic          mem_en_n, mem_wr_n, mem_abort_n, busy_n, rsp_err;
    logic [DW-1:0] f_rdata_n, d_rdata_n, mem_wdata_n, rsp_rdata;
    logic [AW-1:0] mem_addr_n;

    assign in_mem = (state == ISSUE) || (state == WAIT);

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_mem),
        .en      (in_mem),
        .expired (wd_expired)
    );

    // Grant choice and the operands it selects; only IDLE may replace the held operands.
    always_comb begin
        grant_d = d_req && (!f_req || (run < MAX_RUN));
        grant_f = f_req && !grant_d;
        owner_n = owner_q;
        addr_n  = addr_q;
        wr_n    = wr_q;
        wdata_n = wdata_q;
        if (state == IDLE) begin
            owner_n = grant_d ? OWN_D : OWN_F;
            addr_n  = grant_d ? d_addr : f_addr;
            wr_n    = grant_d && d_wr;
            wdata_n = (grant_d && d_wr) ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (f_req || d_req) next_state = addr_n[0] ? RESP : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (mem_abort || mem_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the coming state.
    always_comb begin
        mem_en_n    = 1'b0;
        mem_wr_n    = 1'b0;
        mem_addr_n  = '0;
        mem_wdata_n = '0;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        f_done_n    = 1'b0;
        f_rdata_n   = '0;
        f_err_n     = 1'b0;
        d_done_n    = 1'b0;
        d_rdata_n   = '0;
        d_err_n     = 1'b0;
        busy_n      = (next_state != IDLE);
        mem_abort_n = (state == WAIT) && !mem_abort && !mem_done && wd_expired;
        if (next_state == ISSUE) begin
            mem_en_n = 1'b1;
            mem_wr_n = wr_n;
        end
        if (next_state == ISSUE || next_state == WAIT) begin
            mem_addr_n  = addr_n;
            mem_wdata_n = wdata_n;
        end
        if (next_state == RESP) begin
            // From IDLE only a misaligned grant reaches RESP; after an abort any mem_done is stale.
            if (state == IDLE || mem_abort) begin
                rsp_err = 1'b1;
            end else if (!wr_q) begin
                rsp_rdata = mem_rdata;
            end
            if (owner_n == OWN_F) begin
                f_done_n  = 1'b1;
                f_rdata_n = rsp_rdata;
                f_err_n   = rsp_err;
            end else begin
                d_done_n  = 1'b1;
                d_rdata_n = rsp_rdata;
                d_err_n   = rsp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run     <= '0;
            owner_q <= OWN_F;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            owner_q <= owner_n;
            addr_q  <= addr_n;
            wr_q    <= wr_n;
            wdata_q <= wdata_n;
            if (state == IDLE) begin
                if (grant_d) begin
                    if (run != 4'hF) run <= run + 4'd1;
                end else if (grant_f) begin
                    run <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_done    <= 1'b0;
            f_rdata   <= '0;
            f_err     <= 1'b0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_abort <= 1'b0;
            busy      <= 1'b0;
        end else begin
            f_done    <= f_done_n;
            f_rdata   <= f_rdata_n;
            f_err     <= f_err_n;
            d_done    <= d_done_n;
            d_rdata   <= d_rdata_n;
            d_err     <= d_err_n;
            mem_en    <= mem_en_n;
            mem_wr    <= mem_wr_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_abort <= mem_abort_n;
            busy      <= busy_n;
        end
    end

endmodule
